// File: rtl/wb_queue.sv
// In-order writeback queue feeding the register-file write port.
// Accepts ALU/load results, drains one per cycle, and forwards the youngest queued value to two readers.
module wb_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    output logic                       alu_ready,

    input  logic                       mem_valid,
    input  logic [4:0]                 mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    output logic                       mem_ready,

    input  logic                       drain_en,
    output logic                       RegWrite,
    output logic [4:0]                 rd,
    output logic [XLEN-1:0]            write_data,

    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    output logic                       fwd1_hit,
    output logic [XLEN-1:0]            fwd1_data,
    output logic                       fwd2_hit,
    output logic [XLEN-1:0]            fwd2_data,

    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t entry_q [DEPTH];

    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    cnt_t   count_q, count_d;

    logic   mem_fire;
    logic   alu_fire;
    logic   push;
    logic   pop;
    entry_t in_entry;
    entry_t head_entry;

    // ------------------------------------------------------------------
    // Status and handshake. Ready depends only on registered occupancy,
    // so a full queue stays closed even in a cycle that drains.
    // ------------------------------------------------------------------
    assign full      = (count_q == cnt_t'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    always_comb begin
        mem_fire = mem_valid && mem_ready;
        alu_fire = alu_valid && alu_ready;

        in_entry.rd   = alu_rd;
        in_entry.data = alu_data;
        if (mem_fire) begin
            in_entry.rd   = mem_rd;
            in_entry.data = mem_data;
        end

        // x0 results complete the handshake but never occupy a slot
        push = (mem_fire || alu_fire) && (in_entry.rd != 5'd0);
        pop  = RegWrite;
    end

    // ------------------------------------------------------------------
    // Drain port: always presents the head entry, zero when empty.
    // ------------------------------------------------------------------
    always_comb begin
        head_entry = entry_q[head_q];
        RegWrite   = !empty && drain_en;
        rd         = '0;
        write_data = '0;
        if (!empty) begin
            rd         = head_entry.rd;
            write_data = head_entry.data;
        end
    end

    // ------------------------------------------------------------------
    // Pointer and occupancy next-state.
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (pop) begin
            head_d = head_q + ptr_t'(1);
        end
        if (push) begin
            tail_d = tail_q + ptr_t'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; every read of it is qualified by count_q,
    // so stale contents are never visible after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[tail_q] <= in_entry;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: scan oldest to youngest so the last match wins.
    // Only registered entries are scanned; this cycle's push is not seen.
    // ------------------------------------------------------------------
    always_comb begin
        ptr_t idx;

        idx       = head_q;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;

        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + ptr_t'(i);
            if (cnt_t'(i) < count_q) begin
                if ((rs1 != 5'd0) && (entry_q[idx].rd == rs1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = entry_q[idx].data;
                end
                if ((rs2 != 5'd0) && (entry_q[idx].rd == rs2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = entry_q[idx].data;
                end
            end
        end
    end

endmodule
